// File: rtl/ram_if.sv
// ram_if: request/response bundle between the EX/MEM pipeline register and the data-memory responder
//   i_e_read_ram, i_e_write_ram : read / write request enables
//   i_address_ram               : 32-bit byte address
//   i_din_ram                   : 32-bit write data
//   o_busy                      : access in flight, upstream holds its request
//   o_done, o_error             : one-cycle completion pulse and illegal-request flag
//   o_dout_ram                  : read data, valid with o_done
interface ram_if;
    logic        i_e_read_ram;
    logic        i_e_write_ram;
    logic [31:0] i_address_ram;
    logic [31:0] i_din_ram;
    logic        o_busy;
    logic        o_done;
    logic        o_error;
    logic [31:0] o_dout_ram;
    modport master (
        output i_e_read_ram, i_e_write_ram, i_address_ram, i_din_ram,
        input  o_busy, o_done, o_error, o_dout_ram
    );
    modport slave (
        input  i_e_read_ram, i_e_write_ram, i_address_ram, i_din_ram,
        output o_busy, o_done, o_error, o_dout_ram
    );
endinterface

// File: rtl/ram_responder.sv
// ram_responder: word-array data memory answering read/write requests after a fixed access latency
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : ram_if slave side (requests in; busy/done/error/read data out)
module ram_responder #(
    parameter int DEPTH_LOG2 = 6,
    parameter int LATENCY    = 2
) (
    input  logic clk,
    input  logic rst_n,
    ram_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t                state, state_n;
    logic [3:0]            cnt;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [31:0]           din_q;
    logic                  wr_q;
    logic                  err_q;
    logic                  error_q;
    logic [31:0]           dout_q;
    logic [31:0]           mem [2**DEPTH_LOG2];
    logic                  req;
    logic                  bad;
    logic                  go;
    always_comb begin
        req = bus.i_e_read_ram | bus.i_e_write_ram;
        bad = (|bus.i_address_ram[1:0]) | (|bus.i_address_ram[31:DEPTH_LOG2+2])
            | (bus.i_e_read_ram & bus.i_e_write_ram);
        go = (state == WAIT) && (cnt == 4'd0);
        state_n = (state == IDLE) ? (req ? WAIT : IDLE)
                : (state == WAIT) ? (go ? DONE : WAIT)
                : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            idx_q   <= '0;
            din_q   <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            error_q <= 1'b0;
            dout_q  <= '0;
        end else begin
            if (state == IDLE && req) begin
                cnt   <= 4'(LATENCY - 1);
                idx_q <= bus.i_address_ram[DEPTH_LOG2+1:2];
                din_q <= bus.i_din_ram;
                wr_q  <= bus.i_e_write_ram;
                err_q <= bad;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            // error is only meaningful alongside done, so it lives for the DONE cycle only
            error_q <= go & err_q;
            if (go && err_q)            dout_q <= '0;
            else if (go && !wr_q)       dout_q <= mem[idx_q];
        end
    end
    // Array is deliberately outside the reset domain; a reset mid-access forces IDLE, so go
    // stays low and the pending write is dropped.
    always_ff @(posedge clk) begin
        if (go && wr_q && !err_q) mem[idx_q] <= din_q;
    end
    assign bus.o_busy     = state != IDLE;
    assign bus.o_done     = state == DONE;
    assign bus.o_error    = error_q;
    assign bus.o_dout_ram = dout_q;
endmodule
